// File: rtl/sprite_pkg.sv
// sprite_pkg: shared field widths, descriptor layout helpers and FSM encoding for sprite_table.
package sprite_pkg;
  localparam int DEF_NUM_OBJ  = 8;
  localparam int DEF_FRAME_W  = 3;
  localparam int DEF_TYPE_W   = 2;
  localparam int DEF_HPOS_W   = 11;
  localparam int DEF_VPOS_W   = 10;
  localparam int DEF_OFFSET_W = 21;
  localparam int DEF_ANIM_DIV = 8;
  typedef enum logic {IDLE, SWEEP} state_t;
  function automatic int obj_w(input int f, input int t, input int h, input int v);
    return f + t + h + v;
  endfunction
  // Descriptor is {frame, type, hpos, vpos}, so the frame field sits above the other three.
  function automatic int frame_lsb(input int t, input int h, input int v);
    return t + h + v;
  endfunction
endpackage

// File: rtl/sprite_table_scroll_accum.sv
// scroll_accum: scroll offset register, advanced by scroll_step on each vsync fall and wrapped at period.
module scroll_accum #(
  parameter int OFFSET_W = 21,
  parameter int STEP_W   = 11
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                fall,
  input  logic [OFFSET_W-1:0] period,
  input  logic [STEP_W-1:0]   scroll_step,
  output logic [OFFSET_W-1:0] offset
);
  logic [OFFSET_W:0]   sum;
  logic [OFFSET_W-1:0] nxt;
  assign sum = {1'b0, offset} + (OFFSET_W+1)'(scroll_step);
  // A zero period pins the offset at 0 regardless of step.
  assign nxt = period == '0 ? '0
             : sum > {1'b0, period} ? OFFSET_W'(sum - {1'b0, period} - 1'b1)
             : sum[OFFSET_W-1:0];
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) offset <= '0;
    else if (fall) offset <= nxt;
endmodule

// File: rtl/sprite_table.sv
// sprite_table: NUM_OBJ sprite descriptors with per-frame animation sweep, scroll offset and a
// valid/ready write port from game logic.
module sprite_table import sprite_pkg::*; #(
  parameter int NUM_OBJ  = DEF_NUM_OBJ,
  parameter int FRAME_W  = DEF_FRAME_W,
  parameter int TYPE_W   = DEF_TYPE_W,
  parameter int HPOS_W   = DEF_HPOS_W,
  parameter int VPOS_W   = DEF_VPOS_W,
  parameter int OFFSET_W = DEF_OFFSET_W,
  parameter int ANIM_DIV = DEF_ANIM_DIV,
  localparam int OBJ_W   = obj_w(FRAME_W, TYPE_W, HPOS_W, VPOS_W),
  localparam int IDX_W   = NUM_OBJ > 1 ? $clog2(NUM_OBJ) : 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     vsync,
  input  logic [OFFSET_W-1:0]      period,
  input  logic [HPOS_W-1:0]        scroll_step,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [IDX_W-1:0]         wr_index,
  input  logic [OBJ_W-1:0]         wr_data,
  input  logic                     wr_anim,
  output logic [NUM_OBJ*OBJ_W-1:0] obj_bus,
  output logic [OFFSET_W-1:0]      p_offset,
  output logic                     frame_tick,
  output logic                     busy
);
  localparam int FR_LSB = frame_lsb(TYPE_W, HPOS_W, VPOS_W);
  localparam int DIV_W  = ANIM_DIV > 1 ? $clog2(ANIM_DIV) : 1;
  state_t             state;
  logic               vsync_q, fall, sweep_req, pending, go, last, div_last, wr_fire;
  logic [IDX_W-1:0]   idx;
  logic [DIV_W-1:0]   div_cnt;
  logic [OBJ_W-1:0]   obj [NUM_OBJ];
  logic [NUM_OBJ-1:0] anim;
  assign fall     = vsync_q & ~vsync;
  assign div_last = div_cnt == DIV_W'(ANIM_DIV - 1);
  assign last     = idx == IDX_W'(NUM_OBJ - 1);
  assign go       = sweep_req | pending;
  assign wr_ready = state == IDLE;
  assign busy     = state == SWEEP;
  assign wr_fire  = wr_valid & wr_ready;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      vsync_q    <= 1'b0;
      frame_tick <= 1'b0;
      div_cnt    <= '0;
      sweep_req  <= 1'b0;
      pending    <= 1'b0;
      state      <= IDLE;
      idx        <= '0;
    end else begin
      vsync_q    <= vsync;
      frame_tick <= fall;
      sweep_req  <= fall & div_last;
      if (fall) div_cnt <= div_last ? '0 : div_cnt + 1'b1;
      if (state == IDLE) begin
        if (go) begin
          state <= SWEEP;
          idx   <= '0;
        end
      end else if (last) begin
        // A request that arrived mid-sweep restarts the sweep without returning to IDLE.
        state   <= go ? SWEEP : IDLE;
        idx     <= '0;
        pending <= 1'b0;
      end else begin
        idx     <= idx + 1'b1;
        pending <= go;
      end
    end
  // Writes only happen in IDLE and the sweep only in SWEEP, so the two never collide on a slot.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < NUM_OBJ; i++) obj[i] <= '0;
      anim <= '0;
    end else begin
      for (int i = 0; i < NUM_OBJ; i++)
        if (wr_fire && 32'(wr_index) == i) begin
          obj[i]  <= wr_data;
          anim[i] <= wr_anim;
        end else if (state == SWEEP && 32'(idx) == i && anim[i])
          obj[i][FR_LSB +: FRAME_W] <= obj[i][FR_LSB +: FRAME_W] + 1'b1;
    end
  for (genvar i = 0; i < NUM_OBJ; i++) begin : g_bus
    assign obj_bus[i*OBJ_W +: OBJ_W] = obj[i];
  end
  scroll_accum #(.OFFSET_W(OFFSET_W), .STEP_W(HPOS_W)) u_scroll (
    .clock       (clock),
    .reset_n     (reset_n),
    .fall        (fall),
    .period      (period),
    .scroll_step (scroll_step),
    .offset      (p_offset)
  );
endmodule

// File: tb/tb_sprite_table.sv
// tb_sprite_table: directed checks of reset, scroll wrap, animation sweep, write handshake and
// asynchronous reset for sprite_table with default parameters.
module tb_sprite_table;
  logic         clock = 1'b0, reset_n = 1'b0, vsync = 1'b0;
  logic [20:0]  period = '0;
  logic [10:0]  scroll_step = '0;
  logic         wr_valid = 1'b0, wr_anim = 1'b0, wr_ready;
  logic [2:0]   wr_index = '0;
  logic [25:0]  wr_data = '0;
  logic [207:0] obj_bus;
  logic [20:0]  p_offset;
  logic         frame_tick, busy;
  int           cmp = 0, errs = 0, ticks, bcnt;
  logic [20:0]  off_c;

  sprite_table dut (
    .clock(clock), .reset_n(reset_n), .vsync(vsync), .period(period), .scroll_step(scroll_step),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_index(wr_index), .wr_data(wr_data),
    .wr_anim(wr_anim), .obj_bus(obj_bus), .p_offset(p_offset), .frame_tick(frame_tick), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic [25:0] desc(input logic [2:0] f, input logic [1:0] t,
                                       input logic [10:0] h, input logic [9:0] v);
    return {f, t, h, v};
  endfunction

  function automatic logic [25:0] slot(input int i);
    return obj_bus[i*26 +: 26];
  endfunction

  // One vsync high/low pulse; ticks counts frame_tick over the window, off_c is the offset after the fall.
  task automatic vpulse();
    ticks = 0;
    vsync = 1'b1; @(negedge clock); ticks += int'(frame_tick);
    vsync = 1'b0; @(negedge clock); ticks += int'(frame_tick); off_c = p_offset;
    @(negedge clock); ticks += int'(frame_tick);
  endtask

  task automatic pulses(input int n);
    repeat (n) vpulse();
  endtask

  task automatic do_write(input logic [2:0] i, input logic [25:0] d, input logic a);
    wr_valid = 1'b1; wr_index = i; wr_data = d; wr_anim = a;
    @(negedge clock);
    wr_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    cmp++; if (obj_bus !== '0) begin errs++; $display("FAIL reset_obj_bus got %h exp 0", obj_bus); end
    cmp++; if (p_offset !== 21'd0) begin errs++; $display("FAIL reset_p_offset got %0d exp 0", p_offset); end
    cmp++; if (wr_ready !== 1'b1) begin errs++; $display("FAIL reset_wr_ready got %b exp 1", wr_ready); end
    cmp++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b exp 0", busy); end
    cmp++; if (frame_tick !== 1'b0) begin errs++; $display("FAIL reset_frame_tick got %b exp 0", frame_tick); end
  endtask

  task automatic test_scroll();
    period = 21'd10; scroll_step = 11'd1;
    for (int k = 1; k <= 12; k++) begin
      vpulse();
      cmp++; if (off_c !== 21'(k <= 10 ? k : k - 11)) begin errs++; $display("FAIL scroll_offset[%0d] got %0d exp %0d", k, off_c, k <= 10 ? k : k - 11); end
      cmp++; if (ticks != 1) begin errs++; $display("FAIL scroll_ticks[%0d] got %0d exp 1", k, ticks); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    period = 21'd100; scroll_step = 11'd7;
    pulses(14);
    cmp++; if (p_offset !== 21'd98) begin errs++; $display("FAIL wrap_pre got %0d exp 98", p_offset); end
    vpulse();
    cmp++; if (off_c !== 21'd4) begin errs++; $display("FAIL wrap_98_plus_7 got %0d exp 4", off_c); end
    period = 21'd0;
    vpulse();
    cmp++; if (off_c !== 21'd0) begin errs++; $display("FAIL wrap_period0_a got %0d exp 0", off_c); end
    vpulse();
    cmp++; if (off_c !== 21'd0) begin errs++; $display("FAIL wrap_period0_b got %0d exp 0", off_c); end
  endtask

  task automatic test_anim();
    do_reset();
    period = '0; scroll_step = '0;
    do_write(3'd3, desc(3'd0, 2'd0, 11'd256, 10'd256), 1'b1);
    do_write(3'd5, desc(3'd5, 2'd1, 11'd10, 10'd20), 1'b0);
    pulses(16);
    repeat (12) @(negedge clock);
    cmp++; if (slot(3) !== desc(3'd2, 2'd0, 11'd256, 10'd256)) begin errs++; $display("FAIL anim_slot3 got %h exp %h", slot(3), desc(3'd2, 2'd0, 11'd256, 10'd256)); end
    cmp++; if (slot(5) !== desc(3'd5, 2'd1, 11'd10, 10'd20)) begin errs++; $display("FAIL anim_slot5_static got %h exp %h", slot(5), desc(3'd5, 2'd1, 11'd10, 10'd20)); end
    cmp++; if (slot(0) !== 26'd0) begin errs++; $display("FAIL anim_slot0 got %h exp 0", slot(0)); end
    do_write(3'd3, desc(3'd7, 2'd2, 11'd256, 10'd256), 1'b1);
    pulses(8);
    repeat (12) @(negedge clock);
    cmp++; if (slot(3) !== desc(3'd0, 2'd2, 11'd256, 10'd256)) begin errs++; $display("FAIL anim_wrap got %h exp %h", slot(3), desc(3'd0, 2'd2, 11'd256, 10'd256)); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    do_write(3'd3, desc(3'd0, 2'd0, 11'd1, 10'd1), 1'b1);
    pulses(7);
    vsync = 1'b1; @(negedge clock);
    vsync = 1'b0; @(negedge clock);
    cmp++; if (frame_tick !== 1'b1) begin errs++; $display("FAIL b2b_tick got %b exp 1", frame_tick); end
    cmp++; if (busy !== 1'b0) begin errs++; $display("FAIL b2b_busy_at_tick got %b exp 0", busy); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      cmp++; if (busy !== 1'b1) begin errs++; $display("FAIL b2b_busy[%0d] got %b exp 1", k, busy); end
      cmp++; if (wr_ready !== 1'b0) begin errs++; $display("FAIL b2b_ready[%0d] got %b exp 0", k, wr_ready); end
      if (k == 3) begin
        cmp++; if (slot(3) !== desc(3'd0, 2'd0, 11'd1, 10'd1)) begin errs++; $display("FAIL b2b_slot3_early got %h exp %h", slot(3), desc(3'd0, 2'd0, 11'd1, 10'd1)); end
      end
      if (k == 4) begin
        cmp++; if (slot(3) !== desc(3'd1, 2'd0, 11'd1, 10'd1)) begin errs++; $display("FAIL b2b_slot3_timed got %h exp %h", slot(3), desc(3'd1, 2'd0, 11'd1, 10'd1)); end
      end
      if (k == 0) begin
        wr_valid = 1'b1; wr_index = 3'd2; wr_data = desc(3'd4, 2'd3, 11'd100, 10'd50); wr_anim = 1'b0;
      end
    end
    @(negedge clock);
    cmp++; if (busy !== 1'b0) begin errs++; $display("FAIL b2b_busy_end got %b exp 0", busy); end
    cmp++; if (wr_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready_end got %b exp 1", wr_ready); end
    cmp++; if (slot(2) !== 26'd0) begin errs++; $display("FAIL b2b_slot2_held got %h exp 0", slot(2)); end
    @(negedge clock);
    wr_valid = 1'b0;
    cmp++; if (slot(2) !== desc(3'd4, 2'd3, 11'd100, 10'd50)) begin errs++; $display("FAIL b2b_slot2_written got %h exp %h", slot(2), desc(3'd4, 2'd3, 11'd100, 10'd50)); end
    pulses(7);
    vsync = 1'b1; @(negedge clock);
    vsync = 1'b0;
    wr_valid = 1'b1; wr_index = 3'd6; wr_data = desc(3'd2, 2'd0, 11'd5, 10'd5); wr_anim = 1'b1;
    @(negedge clock);
    wr_valid = 1'b0;
    repeat (12) @(negedge clock);
    cmp++; if (slot(6) !== desc(3'd3, 2'd0, 11'd5, 10'd5)) begin errs++; $display("FAIL wr_edge_slot6 got %h exp %h", slot(6), desc(3'd3, 2'd0, 11'd5, 10'd5)); end
    cmp++; if (slot(3) !== desc(3'd2, 2'd0, 11'd1, 10'd1)) begin errs++; $display("FAIL wr_edge_slot3 got %h exp %h", slot(3), desc(3'd2, 2'd0, 11'd1, 10'd1)); end
  endtask

  task automatic test_reset_mid_sweep();
    do_reset();
    period = 21'd50; scroll_step = 11'd3;
    do_write(3'd1, desc(3'd0, 2'd0, 11'd7, 10'd7), 1'b1);
    pulses(7);
    vsync = 1'b1; @(negedge clock);
    vsync = 1'b0; @(negedge clock);
    repeat (2) @(negedge clock);
    cmp++; if (busy !== 1'b1) begin errs++; $display("FAIL mid_busy_before got %b exp 1", busy); end
    #2 reset_n = 1'b0;
    #1;
    cmp++; if (busy !== 1'b0) begin errs++; $display("FAIL mid_busy got %b exp 0", busy); end
    cmp++; if (wr_ready !== 1'b1) begin errs++; $display("FAIL mid_ready got %b exp 1", wr_ready); end
    cmp++; if (obj_bus !== '0) begin errs++; $display("FAIL mid_obj_bus got %h exp 0", obj_bus); end
    cmp++; if (p_offset !== 21'd0) begin errs++; $display("FAIL mid_offset got %0d exp 0", p_offset); end
    cmp++; if (frame_tick !== 1'b0) begin errs++; $display("FAIL mid_tick got %b exp 0", frame_tick); end
    @(negedge clock);
    reset_n = 1'b1;
    period = '0;
    @(negedge clock);
    do_write(3'd1, desc(3'd0, 2'd0, 11'd7, 10'd7), 1'b1);
    pulses(7);
    vsync = 1'b1; @(negedge clock);
    vsync = 1'b0; @(negedge clock);
    bcnt = 0;
    repeat (12) begin
      @(negedge clock);
      bcnt += int'(busy);
    end
    cmp++; if (bcnt != 8) begin errs++; $display("FAIL mid_resweep_len got %0d exp 8", bcnt); end
    cmp++; if (slot(1) !== desc(3'd1, 2'd0, 11'd7, 10'd7)) begin errs++; $display("FAIL mid_resweep_slot1 got %h exp %h", slot(1), desc(3'd1, 2'd0, 11'd7, 10'd7)); end
  endtask

  initial begin
    test_reset();
    test_scroll();
    test_wrap();
    test_anim();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "watchdog");
  end
endmodule
